run_ctrl_seq: RTL and testbench

Synthesizable run-control sequencer that replaces hand-scripted simulation stimulus for `start`/`halt`. After reset it issues per-layer start pulses across `NUM_CH` channels in order, waits for each layer's done pulse, and supports halt/resume, optional looping and a per-layer timeout. It sits above the layer tops (e.g. the CONV1 dense top) and drives their `start`/`halt` inputs.

---
 rtl/run_ctrl_pkg.sv | 23 ++
 rtl/run_cnt.sv | 49 ++++
 rtl/run_ctrl_seq.sv | 211 +++++++++++++++++++++
 tb/tb_run_ctrl_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// run_ctrl_pkg
// Shared types and helpers for the run-control sequencer.
//   run_state_t : sequencer FSM state encoding
//   ch_width()  : width of the channel index (at least 1 bit)
// -----------------------------------------------------------------------------
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_RUN    = 3'd3,
        ST_HALTED = 3'd4,
        ST_ERR    = 3'd5
    } run_state_t;

    // A single channel still needs a 1-bit index port.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_cnt.sv
// -----------------------------------------------------------------------------
// run_cnt
// Generic counter with clear / load / enable / hold and a terminal flag.
// Priority: clear > load > enable; otherwise the value holds.
//   i_clk, i_rst   : clock, synchronous active-high reset (value <- RST_VAL)
//   i_clr          : force value to 0
//   i_load         : load i_load_val
//   i_load_val     : value for load
//   i_en           : step by one (down when i_down, else up)
//   i_down         : count direction
//   i_term_val     : compare value for the terminal flag
//   o_term         : high while current value equals i_term_val
// -----------------------------------------------------------------------------
module run_cnt #(
    parameter int unsigned       CNT_W   = 16,
    parameter logic [CNT_W-1:0]  RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_down,
    input  logic [CNT_W-1:0] i_term_val,
    output logic             o_term
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= RST_VAL;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            if (i_down) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_term = (r_cnt == i_term_val);

endmodule

// File: rtl/run_ctrl_seq.sv
// -----------------------------------------------------------------------------
// run_ctrl_seq
// Run-control sequencer: after a settle period it waits for go, then issues a
// start pulse to each channel in turn and waits for that channel's done pulse.
// Supports halt/resume, optional looping and a per-channel RUN timeout.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_go             : begin a pass (sampled in IDLE only)
//   i_loop_en        : restart at channel 0 after the last channel
//   i_halt_req       : pause the running channel
//   i_resume         : leave HALTED
//   i_layer_done     : per-channel one-cycle done pulse
//   o_start          : one-hot start pulse (START_W cycles) to o_cur_ch
//   o_halt           : high while HALTED
//   o_busy           : high in ISSUE, RUN, HALTED
//   o_cur_ch         : channel being run
//   o_all_done       : one-cycle pulse when the last channel completes
//   o_timeout_err    : sticky until reset
// -----------------------------------------------------------------------------
module run_ctrl_seq
    import run_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned START_W = 1,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_go,
    input  logic                        i_loop_en,
    input  logic                        i_halt_req,
    input  logic                        i_resume,
    input  logic [NUM_CH-1:0]           i_layer_done,
    output logic [NUM_CH-1:0]           o_start,
    output logic                        o_halt,
    output logic                        o_busy,
    output logic [ch_width(NUM_CH)-1:0] o_cur_ch,
    output logic                        o_all_done,
    output logic                        o_timeout_err
);

    localparam int unsigned       CH_W    = ch_width(NUM_CH);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] ONE_CH  = NUM_CH'(1);

    run_state_t        r_state;
    run_state_t        w_state_nx;
    logic [CH_W-1:0]   r_cur_ch;
    logic [CH_W-1:0]   w_cur_ch_nx;
    logic [NUM_CH-1:0] r_start;
    logic [NUM_CH-1:0] w_start_nx;
    logic              r_halt;
    logic              r_busy;
    logic              r_all_done;
    logic              r_timeout_err;
    logic              w_all_done_nx;

    // settle / start-pulse down-counter controls
    logic              w_pc_load;
    logic              w_pc_en;
    logic              w_pc_term;
    // timeout up-counter controls
    logic              w_to_clr;
    logic              w_to_en;
    logic              w_to_term;

    logic              w_done_hit;

    assign w_done_hit = i_layer_done[r_cur_ch];

    // One counter serves both the settle wait and the start pulse width, since
    // the two phases never overlap; reset preloads it with SETTLE-1.
    run_cnt #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(SETTLE - 1))
    ) u_pulse_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (1'b0),
        .i_load     (w_pc_load),
        .i_load_val (CNT_W'(START_W - 1)),
        .i_en       (w_pc_en),
        .i_down     (1'b1),
        .i_term_val ('0),
        .o_term     (w_pc_term)
    );

    run_cnt #(
        .CNT_W   (CNT_W),
        .RST_VAL ('0)
    ) u_timeout_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_to_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_to_en),
        .i_down     (1'b0),
        .i_term_val (CNT_W'(TIMEOUT - 1)),
        .o_term     (w_to_term)
    );

    always_comb begin
        w_state_nx    = r_state;
        w_cur_ch_nx   = r_cur_ch;
        w_all_done_nx = 1'b0;
        w_pc_load     = 1'b0;
        w_pc_en       = 1'b0;
        w_to_clr      = 1'b0;
        w_to_en       = 1'b0;

        unique case (r_state)
            ST_SETTLE: begin
                if (w_pc_term) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_pc_en = 1'b1;
                end
            end

            ST_IDLE: begin
                if (i_go) begin
                    w_state_nx  = ST_ISSUE;
                    w_cur_ch_nx = '0;
                    w_pc_load   = 1'b1;
                end
            end

            ST_ISSUE: begin
                if (w_pc_term) begin
                    w_state_nx = ST_RUN;
                    w_to_clr   = 1'b1;
                end else begin
                    w_pc_en = 1'b1;
                end
            end

            // Done is honoured in both RUN and HALTED and beats halt/timeout.
            ST_RUN, ST_HALTED: begin
                if (w_done_hit) begin
                    if (r_cur_ch != LAST_CH) begin
                        w_state_nx  = ST_ISSUE;
                        w_cur_ch_nx = r_cur_ch + CH_W'(1);
                        w_pc_load   = 1'b1;
                    end else begin
                        w_all_done_nx = 1'b1;
                        if (i_loop_en) begin
                            w_state_nx  = ST_ISSUE;
                            w_cur_ch_nx = '0;
                            w_pc_load   = 1'b1;
                        end else begin
                            w_state_nx = ST_IDLE;
                        end
                    end
                end else if (r_state == ST_RUN) begin
                    if (i_halt_req) begin
                        w_state_nx = ST_HALTED;
                    end else if (w_to_term) begin
                        w_state_nx = ST_ERR;
                    end else begin
                        w_to_en = 1'b1;
                    end
                end else if (i_resume) begin
                    w_state_nx = ST_RUN;
                end
            end

            ST_ERR: begin
                w_state_nx = ST_ERR;
            end

            default: begin
                w_state_nx = ST_SETTLE;
            end
        endcase

        // The start vector is a pure function of the next state and channel,
        // which keeps it registered without separate set/clear bookkeeping.
        w_start_nx = (w_state_nx == ST_ISSUE) ? (ONE_CH << w_cur_ch_nx) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_SETTLE;
            r_cur_ch      <= '0;
            r_start       <= '0;
            r_halt        <= 1'b0;
            r_busy        <= 1'b0;
            r_all_done    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cur_ch      <= w_cur_ch_nx;
            r_start       <= w_start_nx;
            r_halt        <= (w_state_nx == ST_HALTED);
            r_busy        <= (w_state_nx == ST_ISSUE) || (w_state_nx == ST_RUN) ||
                             (w_state_nx == ST_HALTED);
            r_all_done    <= w_all_done_nx;
            r_timeout_err <= r_timeout_err || (w_state_nx == ST_ERR);
        end
    end

    assign o_start       = r_start;
    assign o_halt        = r_halt;
    assign o_busy        = r_busy;
    assign o_cur_ch      = r_cur_ch;
    assign o_all_done    = r_all_done;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_run_ctrl_seq.sv
module tb_run_ctrl_seq;

    logic       clk;
    logic       rst;
    logic       go;
    logic       loop_en;
    logic       halt_req;
    logic       resume;
    logic [3:0] layer_done;
    logic [3:0] start;
    logic       halt;
    logic       busy;
    logic [1:0] cur_ch;
    logic       all_done;
    logic       terr;

    // second instance with a 3-cycle start pulse
    logic       go3;
    logic [3:0] ld3;
    logic [3:0] start3;
    logic       halt3;
    logic       busy3;
    logic [1:0] cur3;
    logic       ad3;
    logic       terr3;

    int unsigned errors = 0;
    int unsigned checks = 0;

    run_ctrl_seq #(
        .NUM_CH  (4),
        .SETTLE  (2),
        .START_W (1),
        .TIMEOUT (64),
        .CNT_W   (16)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_go          (go),
        .i_loop_en     (loop_en),
        .i_halt_req    (halt_req),
        .i_resume      (resume),
        .i_layer_done  (layer_done),
        .o_start       (start),
        .o_halt        (halt),
        .o_busy        (busy),
        .o_cur_ch      (cur_ch),
        .o_all_done    (all_done),
        .o_timeout_err (terr)
    );

    run_ctrl_seq #(
        .NUM_CH  (4),
        .SETTLE  (2),
        .START_W (3),
        .TIMEOUT (64),
        .CNT_W   (16)
    ) dut3 (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_go          (go3),
        .i_loop_en     (1'b0),
        .i_halt_req    (1'b0),
        .i_resume      (1'b0),
        .i_layer_done  (ld3),
        .o_start       (start3),
        .o_halt        (halt3),
        .o_busy        (busy3),
        .o_cur_ch      (cur3),
        .o_all_done    (ad3),
        .o_timeout_err (terr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge; outputs are read 1 time unit after it and
    // inputs changed here are sampled at the following edge.
    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic done_pulse(input logic [3:0] mask);
        layer_done = mask;
        tick();
        layer_done = '0;
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; loop_en = 1'b0; halt_req = 1'b0; resume = 1'b0;
        layer_done = '0; go3 = 1'b0; ld3 = '0;
        tick(2);
        // reset state: {start,halt,busy,cur_ch,all_done,terr}
        chk("rst_outputs", {start, halt, busy, cur_ch, all_done, terr}, 32'h0);

        // go during SETTLE is ignored
        rst = 1'b0;
        go  = 1'b1;
        tick(2);
        chk("settle_go_busy", busy, 1'b0);
        chk("settle_go_start", start, 4'b0000);
        go = 1'b0;
        tick();
        chk("idle_busy", busy, 1'b0);

        // accepted go
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("go_start0", start, 4'b0001);
        chk("go_busy", busy, 1'b1);
        chk("go_cur", cur_ch, 2'd0);
        tick();
        chk("start0_1cyc", start, 4'b0000);
        chk("run0_busy", busy, 1'b1);

        // ch0 done, ch1 start back-to-back
        tick(3);
        done_pulse(4'b0001);
        chk("adv_start1", start, 4'b0010);
        chk("adv_cur1", cur_ch, 2'd1);
        tick();
        // done of a different channel is ignored
        done_pulse(4'b0001);
        chk("wrong_done_start", start, 4'b0000);
        chk("wrong_done_cur", cur_ch, 2'd1);
        tick(2);
        done_pulse(4'b0010);
        chk("adv_start2", start, 4'b0100);
        tick(4);
        done_pulse(4'b0100);
        chk("adv_start3", start, 4'b1000);
        chk("adv_cur3", cur_ch, 2'd3);
        tick(4);
        done_pulse(4'b1000);
        chk("last_alldone", all_done, 1'b1);
        chk("last_busy", busy, 1'b0);
        chk("last_start", start, 4'b0000);
        tick();
        chk("alldone_pulse", all_done, 1'b0);

        // loop mode pass
        loop_en = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("loop_start0", start, 4'b0001);
        tick(2); done_pulse(4'b0001);
        tick(2); done_pulse(4'b0010);
        tick(2); done_pulse(4'b0100);
        tick(2); done_pulse(4'b1000);
        chk("loop_alldone", all_done, 1'b1);
        chk("loop_restart", start, 4'b0001);
        chk("loop_cur", cur_ch, 2'd0);
        chk("loop_busy", busy, 1'b1);
        loop_en = 1'b0;

        // halt/resume on ch1
        tick();
        done_pulse(4'b0001);
        chk("h_start1", start, 4'b0010);
        tick(2);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("h_halt_on", halt, 1'b1);
        chk("h_busy", busy, 1'b1);
        tick(99);
        chk("h_halt_held", halt, 1'b1);
        chk("h_no_to", terr, 1'b0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("h_halt_off", halt, 1'b0);
        tick(9);
        done_pulse(4'b0010);
        chk("h_start2", start, 4'b0100);
        chk("h_terr", terr, 1'b0);

        // done wins over simultaneous halt_req
        tick(2);
        layer_done = 4'b0100;
        halt_req = 1'b1;
        tick();
        layer_done = '0;
        halt_req = 1'b0;
        chk("dh_start3", start, 4'b1000);
        chk("dh_halt", halt, 1'b0);

        // done accepted while HALTED
        tick(2);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("hd_halt", halt, 1'b1);
        done_pulse(4'b1000);
        chk("hd_halt_clr", halt, 1'b0);
        chk("hd_alldone", all_done, 1'b1);
        chk("hd_busy", busy, 1'b0);

        // timeout on ch2
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        tick(); done_pulse(4'b0001);
        tick(); done_pulse(4'b0010);
        chk("to_start2", start, 4'b0100);
        tick();
        chk("to_start_end", start, 4'b0000);
        tick(63);
        chk("to_pre", terr, 1'b0);
        chk("to_pre_busy", busy, 1'b1);
        tick();
        chk("to_err", terr, 1'b1);
        chk("to_busy", busy, 1'b0);
        chk("to_start", start, 4'b0000);
        go = 1'b1;
        tick(2);
        go = 1'b0;
        chk("to_go_ign", {start, busy, terr}, {4'b0000, 1'b0, 1'b1});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("to_rst_clr", terr, 1'b0);

        // reset while HALTED
        tick(3);
        go = 1'b1;
        tick();
        go = 1'b0;
        tick(2);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("rh_halt", halt, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rh_outputs", {start, halt, busy, cur_ch, all_done, terr}, 32'h0);
        go = 1'b1;
        tick(2);
        chk("rh_settle_busy", busy, 1'b0);
        tick();
        go = 1'b0;
        chk("rh_go_start", start, 4'b0001);
        chk("rh_go_busy", busy, 1'b1);

        // START_W=3 instance
        go3 = 1'b1;
        tick();
        go3 = 1'b0;
        chk("w3_c1", start3, 4'b0001);
        tick();
        chk("w3_c2", start3, 4'b0001);
        tick();
        chk("w3_c3", start3, 4'b0001);
        tick();
        chk("w3_end", start3, 4'b0000);
        chk("w3_busy", busy3, 1'b1);
        tick(2);
        ld3 = 4'b0001;
        tick();
        ld3 = '0;
        chk("w3_s1_c1", start3, 4'b0010);
        tick(2);
        chk("w3_s1_c3", start3, 4'b0010);
        tick();
        chk("w3_s1_end", start3, 4'b0000);
        chk("w3_misc", {halt3, terr3, ad3, cur3}, {1'b0, 1'b0, 1'b0, 2'd1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
